// File: rtl/sdm_pkg.sv
// Shared constants, FSM state type and saturating arithmetic for the SDM DAC modulator.
package sdm_pkg;

    localparam int unsigned AUDIO_W = 16;
    localparam int          SDM_FS  = 32767;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_UNDERRUN = 2'd2
    } sdm_state_e;

    // a + b clamped to the signed range of a w-bit register (w <= 31)
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned        w);
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = 33'(a) + 33'(b);
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -hi - 33'sd1;
        if (s > hi) begin
            return 32'(hi);
        end else if (s < lo) begin
            return 32'(lo);
        end
        return 32'(s);
    endfunction

endpackage

// File: rtl/sdm_dac_core.sv
// Second-order sigma-delta loop: two saturating integrators and a 1-bit quantiser,
// advanced once per ce.
module sdm_dac_core
    import sdm_pkg::*;
#(
    parameter int unsigned INT1_W = 20,
    parameter int unsigned INT2_W = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic signed [AUDIO_W-1:0] x,
    output logic                      dout,
    output logic                      valid_out
);

    logic signed [INT1_W-1:0] i1_q, i1_d;
    logic signed [INT2_W-1:0] i2_q, i2_d;
    logic                     dout_q, dout_d;
    logic                     valid_q;
    logic signed [31:0]       fb;
    logic signed [31:0]       i1_sum;
    logic signed [31:0]       i2_sum;

    // i2 integrates the freshly updated i1, giving NTF = (1 - z^-1)^2
    always_comb begin
        fb     = dout_q ? 32'(SDM_FS) : -32'(SDM_FS);
        i1_sum = sat_add(32'(i1_q), 32'(x) - fb, INT1_W);
        i2_sum = sat_add(32'(i2_q), i1_sum - fb, INT2_W);
        i1_d   = INT1_W'(i1_sum);
        i2_d   = INT2_W'(i2_sum);
        dout_d = ~i2_sum[31];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1_q    <= '0;
            i2_q    <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= ce;
            if (ce) begin
                i1_q   <= i1_d;
                i2_q   <= i2_d;
                dout_q <= dout_d;
            end
        end
    end

    assign dout      = dout_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/sdm_dac_mod.sv
// Audio-rate to 1-bit SDM transmit modulator: one-deep input buffer, OSR phase counter,
// IDLE/RUN/UNDERRUN control. Define SDM_DAC_INTERP_EN for linear interpolation (default hold).
module sdm_dac_mod
    import sdm_pkg::*;
#(
    parameter int unsigned OSR    = 64,
    parameter int unsigned INT1_W = 20,
    parameter int unsigned INT2_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               din_valid,
    input  logic [AUDIO_W-1:0] din,
    output logic               din_ready,
    output logic               dout,
    output logic               valid_out,
    output logic               underrun
);

    localparam int unsigned PH_W = $clog2(OSR);

    logic [PH_W-1:0]           phase_q, phase_d;
    sdm_state_e                state_q, state_d;
    logic                      buf_empty_q, buf_empty_d;
    logic signed [AUDIO_W-1:0] buf_q, buf_d;
    logic signed [AUDIO_W-1:0] cur_q, cur_d;
    logic                      underrun_q, underrun_d;
    logic signed [AUDIO_W-1:0] din_s;
    logic signed [AUDIO_W-1:0] mod_x;
    logic                      bnd;
    logic                      xfer;
    logic                      load;

    // A boundary only sees the buffer as registered, so a same-cycle transfer waits a period
    always_comb begin
        phase_d     = phase_q;
        state_d     = state_q;
        buf_d       = buf_q;
        buf_empty_d = buf_empty_q;
        cur_d       = cur_q;
        underrun_d  = 1'b0;
        bnd         = ce && (phase_q == PH_W'(OSR - 1));
        xfer        = din_valid && buf_empty_q;
        load        = bnd && !buf_empty_q;
        din_s       = (din == {1'b1, (AUDIO_W - 1)'(0)}) ? AUDIO_W'(-SDM_FS) : din;

        if (ce) begin
            phase_d = bnd ? '0 : phase_q + PH_W'(1);
        end

        if (load) begin
            cur_d       = buf_q;
            buf_empty_d = 1'b1;
        end else if (xfer) begin
            buf_d       = din_s;
            buf_empty_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (load) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bnd && buf_empty_q) begin
                    state_d    = ST_UNDERRUN;
                    underrun_d = 1'b1;
                end
            end
            ST_UNDERRUN: begin
                if (load) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= '0;
            state_q     <= ST_IDLE;
            buf_empty_q <= 1'b1;
            buf_q       <= '0;
            cur_q       <= '0;
            underrun_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            state_q     <= state_d;
            buf_empty_q <= buf_empty_d;
            buf_q       <= buf_d;
            cur_q       <= cur_d;
            underrun_q  <= underrun_d;
        end
    end

`ifdef SDM_DAC_INTERP_EN
    localparam int unsigned ACC_W = AUDIO_W + PH_W;

    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   step_q, step_d;
    logic signed [AUDIO_W:0]   diff;

    // Ramp starts one step above the old target; the last tick lands exactly on the new one
    always_comb begin
        acc_d  = acc_q;
        step_d = step_q;
        diff   = (AUDIO_W + 1)'(buf_q) - (AUDIO_W + 1)'(cur_q);
        if (bnd) begin
            step_d = load ? ACC_W'(diff >>> PH_W) : '0;
            acc_d  = ACC_W'(cur_q) + step_d;
        end else if (ce) begin
            if (phase_q == PH_W'(OSR - 2)) begin
                acc_d = ACC_W'(cur_q);
            end else begin
                acc_d = acc_q + step_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            step_q <= '0;
        end else begin
            acc_q  <= acc_d;
            step_q <= step_d;
        end
    end

    assign mod_x = AUDIO_W'(acc_q);
`else
    assign mod_x = cur_q;
`endif

    sdm_dac_core #(
        .INT1_W (INT1_W),
        .INT2_W (INT2_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .x         (mod_x),
        .dout      (dout),
        .valid_out (valid_out)
    );

    assign din_ready = buf_empty_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_sdm_dac_mod.sv
// Directed self-checking bench for sdm_dac_mod (OSR=64, ce every clock).
module tb_sdm_dac_mod;

    localparam int NBITS = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        din_valid;
    logic [15:0] din;
    logic        din_ready;
    logic        dout;
    logic        valid_out;
    logic        underrun;

    int checks = 0;
    int passes = 0;
    int tick;
    int urun_cnt  = 0;
    int urun_last = 0;
    int xfer_cnt  = 0;
    int vcnt      = 0;
    bit bits [0:NBITS-1];

    always #5 clk = ~clk;

    sdm_dac_mod dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .din_valid (din_valid),
        .din       (din),
        .din_ready (din_ready),
        .dout      (dout),
        .valid_out (valid_out),
        .underrun  (underrun)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) tick <= 0;
        else if (ce) tick <= tick + 1;
    end

    always @(posedge clk) begin
        if (!rst && din_valid && din_ready) xfer_cnt <= xfer_cnt + 1;
    end

    // bit produced by the k-th ce after reset is stored at bits[k]
    always @(negedge clk) begin
        if (valid_out) begin
            vcnt <= vcnt + 1;
            if (tick < NBITS) bits[tick] <= dout;
        end
        if (underrun) begin
            urun_cnt  <= urun_cnt + 1;
            urun_last <= tick;
        end
    end

    function automatic int ones(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(bits[i]);
        return n;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        ce        = 1'b0;
        din_valid = 1'b0;
        din       = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ce  = 1'b1;
    endtask

    task automatic wait_tick(input int t);
        int guard = 0;
        while (tick < t && guard < 50000) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (tick < t) begin
            checks++;
            $display("FAIL wait_tick: tick=%0d required=%0d", tick, t);
        end
    endtask

    task automatic send(input logic [15:0] v);
        int guard = 0;
        while (!din_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!din_ready) begin
            checks++;
            $display("FAIL send_timeout: din_ready=%0b required=1", din_ready);
        end
        din       = v;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b0; din_valid = 1'b0; din = 16'h0000;
        @(negedge clk);
        checks++; if (dout !== 1'b0) $display("FAIL reset_dout: got %b want 0", dout); else passes++;
        checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out); else passes++;
        checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else passes++;
        checks++; if (din_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", din_ready); else passes++;
    endtask

    task automatic test_idle();
        int u0, v0, bad;
        logic [7:0] first;
        do_reset();
        u0 = urun_cnt; v0 = vcnt;
        wait_tick(200);
        first = '0;
        for (int i = 1; i <= 8; i++) first = {first[6:0], bits[i]};
        checks++; if (first !== 8'b1101_0011) $display("FAIL idle_first8: got %b want 11010011", first); else passes++;
        bad = 0;
        for (int s = 9; s <= 169; s++) if (ones(s, s + 31) != 16) bad++;
        checks++; if (bad !== 0) $display("FAIL idle_window16: bad_windows=%0d want 0", bad); else passes++;
        checks++; if (vcnt - v0 !== 200) $display("FAIL idle_valid_count: got %0d want 200", vcnt - v0); else passes++;
        checks++; if (urun_cnt - u0 !== 0) $display("FAIL idle_underrun: got %0d want 0", urun_cnt - u0); else passes++;
        ce = 1'b0;
        @(negedge clk);
        checks++; if (valid_out !== 1'b0) $display("FAIL valid_no_ce: got %b want 0", valid_out); else passes++;
        ce = 1'b1;
    endtask

    task automatic test_dc_half();
        int u0, n;
        do_reset();
        u0 = urun_cnt;
        din = 16'd16384; din_valid = 1'b1;
        wait_tick(1280);
        din_valid = 1'b0;
        n = ones(257, 1280);
        checks++; if (!(n >= 764 && n <= 772)) $display("FAIL dc_half_density: ones=%0d want 764..772", n); else passes++;
        checks++; if (urun_cnt - u0 !== 0) $display("FAIL dc_half_underrun: got %0d want 0", urun_cnt - u0); else passes++;
    endtask

    task automatic test_back_to_back();
        int x0;
        do_reset();
        x0 = xfer_cnt;
        din = 16'd1000; din_valid = 1'b1;
        @(negedge clk);
        checks++; if (din_ready !== 1'b0) $display("FAIL b2b_ready_t1: got %b want 0", din_ready); else passes++;
        wait_tick(63);
        checks++; if (din_ready !== 1'b0) $display("FAIL b2b_ready_t63: got %b want 0", din_ready); else passes++;
        wait_tick(64);
        checks++; if (din_ready !== 1'b1) $display("FAIL b2b_ready_t64: got %b want 1", din_ready); else passes++;
        wait_tick(65);
        checks++; if (din_ready !== 1'b0) $display("FAIL b2b_ready_t65: got %b want 0", din_ready); else passes++;
        wait_tick(640);
        checks++; if (xfer_cnt - x0 !== 10) $display("FAIL b2b_xfers: got %0d want 10", xfer_cnt - x0); else passes++;
        din_valid = 1'b0;

        // sample offered exactly in the boundary cycle must wait one more period
        do_reset();
        wait_tick(63);
        din = 16'd32767; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        checks++; if (din_ready !== 1'b0) $display("FAIL late_captured: din_ready=%b want 0", din_ready); else passes++;
        wait_tick(192);
        checks++; if (ones(65, 128) !== 32) $display("FAIL late_idle_kept: ones=%0d want 32", ones(65, 128)); else passes++;
`ifndef SDM_DAC_INTERP_EN
        checks++; if (ones(129, 192) !== 63) $display("FAIL late_loaded: ones=%0d want 63", ones(129, 192)); else passes++;
`endif
        checks++; if (din_ready !== 1'b1) $display("FAIL late_consumed: din_ready=%b want 1", din_ready); else passes++;
    endtask

    task automatic test_full_scale();
        int n;
        do_reset();
        din = 16'd32767; din_valid = 1'b1;
        wait_tick(6400);
        n = ones(2305, 6400);
        checks++; if (n < 4092) $display("FAIL fs_pos_density: ones=%0d want >=4092", n); else passes++;
        din = 16'h8000;
        wait_tick(12800);
        n = ones(8705, 12800);
        checks++; if (n > 4) $display("FAIL fs_neg_density: ones=%0d want <=4", n); else passes++;
        din = 16'd32767;
        wait_tick(19200);
        n = ones(15105, 19200);
        checks++; if (n < 4092) $display("FAIL fs_relock_density: ones=%0d want >=4092", n); else passes++;
        din_valid = 1'b0;
    endtask

    task automatic test_underrun();
        int u0, n;
        do_reset();
        u0 = urun_cnt;
        for (int k = 0; k < 3; k++) send(16'd16384);
        wait_tick(300);
        checks++; if (urun_cnt - u0 !== 1) $display("FAIL urun_count1: got %0d want 1", urun_cnt - u0); else passes++;
        checks++; if (urun_last !== 256) $display("FAIL urun_tick1: got %0d want 256", urun_last); else passes++;
        wait_tick(1312);
        n = ones(289, 1312);
        checks++; if (!(n >= 764 && n <= 772)) $display("FAIL urun_hold_density: ones=%0d want 764..772", n); else passes++;
        wait_tick(1410);
        checks++; if (urun_cnt - u0 !== 1) $display("FAIL urun_silent: got %0d want 1", urun_cnt - u0); else passes++;
        send(16'd16384);
        wait_tick(1600);
        checks++; if (urun_cnt - u0 !== 2) $display("FAIL urun_count2: got %0d want 2", urun_cnt - u0); else passes++;
        checks++; if (urun_last !== 1536) $display("FAIL urun_tick2: got %0d want 1536", urun_last); else passes++;
    endtask

    task automatic test_midreset();
        logic [7:0] first;
        do_reset();
        din = 16'd32767; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        wait_tick(31);
        #2 rst = 1'b1;
        #1;
        checks++; if (dout !== 1'b0) $display("FAIL midrst_dout: got %b want 0", dout); else passes++;
        checks++; if (valid_out !== 1'b0) $display("FAIL midrst_valid: got %b want 0", valid_out); else passes++;
        checks++; if (underrun !== 1'b0) $display("FAIL midrst_underrun: got %b want 0", underrun); else passes++;
        checks++; if (din_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", din_ready); else passes++;
        @(negedge clk);
        rst = 1'b0;
        wait_tick(128);
        checks++; if (din_ready !== 1'b1) $display("FAIL midrst_ready_after: got %b want 1", din_ready); else passes++;
        first = '0;
        for (int i = 1; i <= 8; i++) first = {first[6:0], bits[i]};
        checks++; if (first !== 8'b1101_0011) $display("FAIL midrst_first8: got %b want 11010011", first); else passes++;
        checks++; if (ones(65, 128) !== 32) $display("FAIL midrst_stays_idle: ones=%0d want 32", ones(65, 128)); else passes++;
    endtask

`ifdef SDM_DAC_INTERP_EN
    task automatic test_interp();
        do_reset();
        din = 16'd32704; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        wait_tick(64);
        checks++; if (dut.mod_x !== 16'sd511) $display("FAIL interp_x0: got %0d want 511", dut.mod_x); else passes++;
        wait_tick(65);
        checks++; if (dut.mod_x !== 16'sd1022) $display("FAIL interp_x1: got %0d want 1022", dut.mod_x); else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_dc_half();
        test_back_to_back();
        test_full_scale();
        test_underrun();
        test_midreset();
`ifdef SDM_DAC_INTERP_EN
        test_interp();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
